// File: rtl/neo_irq_pkg.sv
// rtl/neo_irq_pkg.sv - shared constants, IACK states and priority encoder for neo_irq_ctrl
package neo_irq_pkg;

    localparam int IRQ_L1_VBL = 0;
    localparam int IRQ_L2_TMR = 1;
    localparam int IRQ_L3_RST = 2;

    localparam int ACK_L3 = 0;
    localparam int ACK_L2 = 1;
    localparam int ACK_L1 = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        VPA  = 2'd2,
        DONE = 2'd3
    } iack_state_t;

    // Active-low 68k priority for the highest pending flag; no flag -> 3'b111.
    function automatic logic [2:0] irq_nipl(input logic [2:0] pend);
        if (pend[IRQ_L3_RST])      return 3'b100;
        else if (pend[IRQ_L2_TMR]) return 3'b101;
        else if (pend[IRQ_L1_VBL]) return 3'b110;
        else                       return 3'b111;
    endfunction

endpackage

// File: rtl/neo_irq_ctrl_if.sv
// rtl/neo_irq_ctrl_if.sv - 68k bus signals seen by the interrupt responder
interface neo_irq_ctrl_if;

    logic       WR_IRQ_ACK;
    logic [2:0] M68K_DATA;
    logic [2:0] M68K_FC;
    logic [2:0] M68K_ADDR;
    logic       nAS;
    logic [2:0] nIPL;
    logic       nVPA;

    modport master (
        output WR_IRQ_ACK, M68K_DATA, M68K_FC, M68K_ADDR, nAS,
        input  nIPL, nVPA
    );

    modport slave (
        input  WR_IRQ_ACK, M68K_DATA, M68K_FC, M68K_ADDR, nAS,
        output nIPL, nVPA
    );

endinterface

// File: rtl/neo_irq_pend.sv
// rtl/neo_irq_pend.sv - enable-qualified rising-edge detector feeding a set-priority pending flag
module neo_irq_pend (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic src_i,
    input  logic clr_i,
    output logic pend_o
);

    logic src_dly_q;
    logic pend_q;
    logic pend_d;
    logic rise;

    assign rise = en_i & src_i & ~src_dly_q;

    always_comb begin
        pend_d = pend_q;
        if (rise)
            pend_d = 1'b1;
        else if (clr_i)
            pend_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            src_dly_q <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            if (en_i)
                src_dly_q <= src_i;
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/neo_irq_ctrl.sv
// rtl/neo_irq_ctrl.sv - LSPC interrupt latching, 68k nIPL encoding and autovector IACK responder
module neo_irq_ctrl
    import neo_irq_pkg::*;
#(
    parameter bit          BOOT_IRQ  = 1'b1,
    parameter int unsigned VPA_DELAY = 2
) (
    input  logic           CLK,
    input  logic           nRESETP,
    input  logic           LSPC_EN_6M_N,
    input  logic           TIMER_IRQ,
    input  logic           VBLANK_IRQ,
    output logic [2:0]     IRQ_PEND,
    neo_irq_ctrl_if.slave  m68k
);

    localparam logic [2:0] CNT_INIT = 3'(VPA_DELAY - 1);
    localparam logic [2:0] NIPL_RST = irq_nipl({BOOT_IRQ, 2'b00});

    logic [2:0]  pend;
    logic        ack_l1, ack_l2, ack_l3;
    logic        l3_q, l3_d;
    iack_state_t state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        nvpa_q, nvpa_d;
    logic [2:0]  nipl_q, nipl_d;
    logic        iack_req;
    logic        unused_addr;

    assign ack_l1 = m68k.WR_IRQ_ACK & m68k.M68K_DATA[ACK_L1];
    assign ack_l2 = m68k.WR_IRQ_ACK & m68k.M68K_DATA[ACK_L2];
    assign ack_l3 = m68k.WR_IRQ_ACK & m68k.M68K_DATA[ACK_L3];

    neo_irq_pend u_pend_l1 (
        .clk_i   (CLK),
        .rst_n_i (nRESETP),
        .en_i    (LSPC_EN_6M_N),
        .src_i   (VBLANK_IRQ),
        .clr_i   (ack_l1),
        .pend_o  (pend[IRQ_L1_VBL])
    );

    neo_irq_pend u_pend_l2 (
        .clk_i   (CLK),
        .rst_n_i (nRESETP),
        .en_i    (LSPC_EN_6M_N),
        .src_i   (TIMER_IRQ),
        .clr_i   (ack_l2),
        .pend_o  (pend[IRQ_L2_TMR])
    );

    // Cold-boot flag has no source: reset loads it, software ack is the only way out.
    assign l3_d = ack_l3 ? 1'b0 : l3_q;
    assign pend[IRQ_L3_RST] = l3_q;

    // Every IACK is autovectored; the level on A[3:1] is not needed.
    assign iack_req    = ~m68k.nAS & (m68k.M68K_FC == 3'b111);
    assign unused_addr = ^m68k.M68K_ADDR;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (iack_req) begin
                state_d = WAIT;
                cnt_d   = CNT_INIT;
            end
            WAIT: begin
                if (m68k.nAS)
                    state_d = IDLE;
                else if (cnt_q == 3'd0)
                    state_d = VPA;
                else
                    cnt_d = cnt_q - 3'd1;
            end
            VPA:  if (m68k.nAS) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        nvpa_d = (state_d != VPA);
        // Priority is frozen for the whole acknowledge so the CPU sees a stable level.
        nipl_d = (state_q == IDLE) ? irq_nipl(pend) : nipl_q;
    end

    always_ff @(posedge CLK or negedge nRESETP) begin
        if (!nRESETP) begin
            l3_q    <= BOOT_IRQ;
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            nvpa_q  <= 1'b1;
            nipl_q  <= NIPL_RST;
        end else begin
            l3_q    <= l3_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nvpa_q  <= nvpa_d;
            nipl_q  <= nipl_d;
        end
    end

    assign m68k.nVPA = nvpa_q;
    assign m68k.nIPL = nipl_q;
    assign IRQ_PEND  = pend;

endmodule

// File: tb/tb_neo_irq_ctrl.sv
// tb/tb_neo_irq_ctrl.sv - directed vector bench for neo_irq_ctrl
module tb_neo_irq_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic tmr = 1'b0;
    logic vbl = 1'b0;
    logic [2:0] irq_pend;

    neo_irq_ctrl_if bus ();

    neo_irq_ctrl #(.BOOT_IRQ(1'b1), .VPA_DELAY(2)) dut (
        .CLK          (clk),
        .nRESETP      (rst_n),
        .LSPC_EN_6M_N (en),
        .TIMER_IRQ    (tmr),
        .VBLANK_IRQ   (vbl),
        .IRQ_PEND     (irq_pend),
        .m68k         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       tmr;
        logic       vbl;
        logic       wr;
        logic [2:0] data;
        logic [2:0] exp_pend;
        logic [2:0] exp_nipl;
    } vec_t;

    vec_t vecs[26];
    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    initial begin
        bus.WR_IRQ_ACK = 1'b0;
        bus.M68K_DATA  = 3'b000;
        bus.M68K_FC    = 3'b000;
        bus.M68K_ADDR  = 3'b000;
        bus.nAS        = 1'b1;

        //           en    tmr   vbl   wr    data    pend    nipl
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 3'b011, 3'b111};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b011, 3'b101};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b011, 3'b101};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 3'b001, 3'b101};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b001, 3'b110};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 3'b000, 3'b110};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b111};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 3'b010, 3'b111};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 3'b010, 3'b101};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 3'b000, 3'b101};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b111};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b111};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b111};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 3'b010, 3'b111};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b010, 3'b101};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'b111, 3'b001, 3'b101};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b001, 3'b110};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 3'b001, 3'b110};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b001, 3'b110};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 3'b000, 3'b110};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b111};
        vecs[21] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 3'b111};
        vecs[22] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 3'b011, 3'b111};
        vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b011, 3'b101};
        vecs[24] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b110, 3'b000, 3'b101};
        vecs[25] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b111};

        // Reset with the cold-boot flag pending
        repeat (3) tick();
        check("rst pend", irq_pend, 3'b100);
        check("rst nipl", bus.nIPL, 3'b100);
        check("rst nvpa", {2'b00, bus.nVPA}, 3'b001);
        rst_n = 1'b1;
        tick();
        check("boot pend", irq_pend, 3'b100);
        check("boot nipl", bus.nIPL, 3'b100);
        bus.WR_IRQ_ACK = 1'b1; bus.M68K_DATA = 3'b001;
        tick();
        bus.WR_IRQ_ACK = 1'b0; bus.M68K_DATA = 3'b000;
        check("boot ack pend", irq_pend, 3'b000);
        check("boot ack nipl lag", bus.nIPL, 3'b100);
        tick();
        check("boot ack nipl", bus.nIPL, 3'b111);

        for (int i = 0; i < 26; i++) begin
            en = vecs[i].en; tmr = vecs[i].tmr; vbl = vecs[i].vbl;
            bus.WR_IRQ_ACK = vecs[i].wr; bus.M68K_DATA = vecs[i].data;
            tick();
            check($sformatf("vec%0d pend", i), irq_pend, vecs[i].exp_pend);
            check($sformatf("vec%0d nipl", i), bus.nIPL, vecs[i].exp_nipl);
        end
        en = 1'b0; tmr = 1'b0; vbl = 1'b0;
        bus.WR_IRQ_ACK = 1'b0; bus.M68K_DATA = 3'b000;

        // Timer level held for 100 enables sets the flag once
        en = 1'b1; tmr = 1'b1;
        tick();
        check("hold set", irq_pend, 3'b010);
        bus.WR_IRQ_ACK = 1'b1; bus.M68K_DATA = 3'b010;
        tick();
        bus.WR_IRQ_ACK = 1'b0; bus.M68K_DATA = 3'b000;
        check("hold ack", irq_pend, 3'b000);
        repeat (98) tick();
        check("hold no reset", irq_pend, 3'b000);
        check("hold nipl", bus.nIPL, 3'b111);
        tmr = 1'b0;
        tick();
        check("hold fall", irq_pend, 3'b000);
        tmr = 1'b1;
        tick();
        check("hold re-rise", irq_pend, 3'b010);
        en = 1'b0; tmr = 1'b0;
        bus.WR_IRQ_ACK = 1'b1; bus.M68K_DATA = 3'b010;
        tick();
        bus.WR_IRQ_ACK = 1'b0; bus.M68K_DATA = 3'b000;
        check("hold final ack", irq_pend, 3'b000);
        tick(); tick();

        // IACK with nothing pending; VBlank arrives mid-cycle, nIPL frozen until IDLE
        bus.nAS = 1'b0; bus.M68K_FC = 3'b111; bus.M68K_ADDR = 3'd2;
        tick();
        check("iack e0 nvpa", {2'b00, bus.nVPA}, 3'b001);
        en = 1'b1; vbl = 1'b1;
        tick();
        en = 1'b0; vbl = 1'b0;
        check("iack e1 nvpa", {2'b00, bus.nVPA}, 3'b001);
        check("iack vbl pend", irq_pend, 3'b001);
        tick();
        check("iack e2 nvpa", {2'b00, bus.nVPA}, 3'b000);
        check("iack e2 nipl", bus.nIPL, 3'b111);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("iack hold%0d nvpa", i), {2'b00, bus.nVPA}, 3'b000);
            check($sformatf("iack hold%0d nipl", i), bus.nIPL, 3'b111);
        end
        bus.nAS = 1'b1; bus.M68K_FC = 3'b000;
        tick();
        check("iack done nvpa", {2'b00, bus.nVPA}, 3'b001);
        check("iack done nipl", bus.nIPL, 3'b111);
        tick();
        check("iack idle nipl", bus.nIPL, 3'b111);
        tick();
        check("iack post nipl", bus.nIPL, 3'b110);
        check("iack keeps pend", irq_pend, 3'b001);
        bus.WR_IRQ_ACK = 1'b1; bus.M68K_DATA = 3'b100;
        tick();
        bus.WR_IRQ_ACK = 1'b0; bus.M68K_DATA = 3'b000;
        tick();

        // nAS rises during WAIT: abort, nVPA never asserts
        bus.nAS = 1'b0; bus.M68K_FC = 3'b111;
        tick();
        bus.nAS = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("abort%0d nvpa", i), {2'b00, bus.nVPA}, 3'b001);
        end
        // Non-IACK bus cycle is ignored
        bus.nAS = 1'b0; bus.M68K_FC = 3'b110;
        repeat (4) tick();
        check("fc6 nvpa", {2'b00, bus.nVPA}, 3'b001);
        bus.nAS = 1'b1; bus.M68K_FC = 3'b000;
        tick();

        // Reset taken while nVPA is asserted
        en = 1'b1; tmr = 1'b1;
        tick();
        en = 1'b0; tmr = 1'b0; vbl = 1'b1;
        check("pre-rst pend", irq_pend, 3'b010);
        bus.nAS = 1'b0; bus.M68K_FC = 3'b111;
        repeat (3) tick();
        check("pre-rst nvpa", {2'b00, bus.nVPA}, 3'b000);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst mid nvpa", {2'b00, bus.nVPA}, 3'b001);
        check("rst mid pend", irq_pend, 3'b100);
        check("rst mid nipl", bus.nIPL, 3'b100);
        bus.nAS = 1'b1; bus.M68K_FC = 3'b000;
        tick();
        rst_n = 1'b1;
        tick();
        check("post-rst nvpa", {2'b00, bus.nVPA}, 3'b001);
        en = 1'b1;
        tick();
        en = 1'b0; vbl = 1'b0;
        check("held vbl latched", irq_pend, 3'b101);
        bus.nAS = 1'b0; bus.M68K_FC = 3'b111;
        tick();
        check("re-iack e0", {2'b00, bus.nVPA}, 3'b001);
        tick();
        check("re-iack e1", {2'b00, bus.nVPA}, 3'b001);
        tick();
        check("re-iack e2", {2'b00, bus.nVPA}, 3'b000);
        bus.nAS = 1'b1; bus.M68K_FC = 3'b000;
        tick();
        check("re-iack release", {2'b00, bus.nVPA}, 3'b001);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
